// File: rtl/instr_enc_pkg.sv
// Shared encodings for the instruction encoder/loader and the control decoder bench:
// op_sel values, 6-bit opcode/funct constants and the loader FSM state type.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    SEL_RTYPE = 4'd0,
    SEL_LW    = 4'd1,
    SEL_SW    = 4'd2,
    SEL_BEQ   = 4'd3,
    SEL_ORI   = 4'd4,
    SEL_BGEZ  = 4'd5,
    SEL_JPC   = 4'd6,
    SEL_BALRN = 4'd7,
    SEL_JMADD = 4'd8
  } op_sel_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BGEZ  = 6'b100111;
  localparam logic [5:0] OP_JPC   = 6'b011110;

  localparam logic [5:0] FN_BALRN = 6'b010111;
  localparam logic [5:0] FN_JMADD = 6'b100001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, shamt, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm16);
    return {op, rs, rt, imm16};
  endfunction

endpackage

// File: rtl/instr_word_encode.sv
// Combinational assembler: symbolic op_sel plus register/immediate fields -> 32-bit MIPS word.
// legal is low for op_sel codes 9-15, in which case word is zero.
module instr_word_encode
  import instr_enc_pkg::*;
(
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm16,
  output logic [31:0] word,
  output logic        legal
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op_sel)
      SEL_RTYPE: word = r_word(rs, rt, rd, shamt, funct);
      SEL_BALRN: word = r_word(rs, rt, rd, shamt, FN_BALRN);
      SEL_JMADD: word = r_word(rs, rt, rd, shamt, FN_JMADD);
      SEL_LW:    word = i_word(OP_LW,   rs, rt, imm16);
      SEL_SW:    word = i_word(OP_SW,   rs, rt, imm16);
      SEL_BEQ:   word = i_word(OP_BEQ,  rs, rt, imm16);
      SEL_ORI:   word = i_word(OP_ORI,  rs, rt, imm16);
      SEL_BGEZ:  word = i_word(OP_BGEZ, rs, rt, imm16);
      SEL_JPC:   word = i_word(OP_JPC,  rs, rt, imm16);
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Instruction encoder/loader: accepts symbolic instructions and writes encoded words
// sequentially into instruction memory. Define ENC_CHECKSUM_EN to add the XOR checksum output.
module instr_encode_loader
  import instr_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     finish,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               op_sel,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic [4:0]               shamt,
  input  logic [5:0]               funct,
  input  logic [15:0]              imm16,
  output logic                     imem_we,
  output logic [31:0]              imem_addr,
  output logic [31:0]              imem_wdata,
  output logic [$clog2(DEPTH):0]   word_cnt,
  output logic                     full,
  output logic                     busy,
`ifdef ENC_CHECKSUM_EN
  output logic [31:0]              checksum,
`endif
  output logic                     illegal
);

  localparam int CW = $clog2(DEPTH) + 1;

  ld_state_e   state, state_nxt;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        xfer;
  logic        open_session;

  instr_word_encode u_encode (
    .op_sel (op_sel),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .funct  (funct),
    .imm16  (imm16),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  assign full         = (word_cnt == CW'(DEPTH));
  assign busy         = (state == ST_LOAD) || (state == ST_FLUSH);
  assign in_ready     = (state == ST_LOAD) && !full && !finish;
  assign xfer         = in_valid && in_ready;
  assign open_session = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)    state_nxt = ST_LOAD;
      ST_LOAD:  if (finish)   state_nxt = ST_FLUSH;
      // The write registered in LOAD is on the bus now; leave only once it has gone out.
      ST_FLUSH: if (!imem_we) state_nxt = ST_DONE;
      ST_DONE:  if (start)    state_nxt = ST_LOAD;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: only control/datapath registers are reset here; the asynchronous reset also kills a pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      word_cnt   <= '0;
      illegal    <= 1'b0;
`ifdef ENC_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (open_session) begin
        word_cnt <= '0;
        illegal  <= 1'b0;
`ifdef ENC_CHECKSUM_EN
        checksum <= '0;
`endif
      end else if (xfer) begin
        if (enc_legal) begin
          imem_we    <= 1'b1;
          imem_addr  <= BASE_ADDR + (32'(word_cnt) << 2);
          imem_wdata <= enc_word;
          word_cnt   <= word_cnt + CW'(1);
`ifdef ENC_CHECKSUM_EN
          checksum   <= checksum ^ enc_word;
`endif
        end else begin
          illegal <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader: directed scenarios plus randomized sessions,
// checked against a behavioural model with a write scoreboard drained by a separate monitor.
module tb_instr_encode_loader;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset, start, finish, in_valid;
  logic        in_ready;
  logic [3:0]  op_sel;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic [2:0]  word_cnt;
  logic        full, busy, illegal;
`ifdef ENC_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  instr_encode_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_sel     (op_sel),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .funct      (funct),
    .imm16      (imm16),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .word_cnt   (word_cnt),
    .full       (full),
    .busy       (busy),
`ifdef ENC_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int nwrites = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cnt;
    logic [31:0] csum;
  } exp_t;
  exp_t sb[$];

  // Behavioural model: session phase (0 idle, 1 loading, 2 flushing, 3 done) and counters.
  int          phase;
  int          cnt;
  bit          ill;
  bit          we_out;
  logic [31:0] csum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {legal, word} computed straight from the instruction format table.
  function automatic logic [32:0] ref_enc(input int sel, input logic [4:0] a, input logic [4:0] b,
                                          input logic [4:0] d, input logic [4:0] s,
                                          input logic [5:0] f, input logic [15:0] i);
    logic [5:0] op;
    case (sel)
      0: return {1'b1, 6'b000000, a, b, d, s, f};
      7: return {1'b1, 6'b000000, a, b, d, s, 6'b010111};
      8: return {1'b1, 6'b000000, a, b, d, s, 6'b100001};
      1: op = 6'b100011;
      2: op = 6'b101011;
      3: op = 6'b000100;
      4: op = 6'b001101;
      5: op = 6'b100111;
      6: op = 6'b011110;
      default: return 33'd0;
    endcase
    return {1'b1, op, a, b, i};
  endfunction

  task automatic model_reset();
    phase = 0; cnt = 0; ill = 0; we_out = 0; csum = 0;
    sb.delete();
  endtask

  task automatic idle_inputs();
    start = 0; finish = 0; in_valid = 0;
  endtask

  task automatic set_instr(input int sel, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] d, input logic [4:0] s, input logic [5:0] f,
                           input logic [15:0] i);
    op_sel = 4'(sel); rs = a; rt = b; rd = d; shamt = s; funct = f; imm16 = i;
  endtask

  // Called at posedge+1 with inputs applied; checks status, advances the model, returns at next posedge+1.
  task automatic cycle();
    logic        exp_ready;
    logic [32:0] enc;
    bit          xfer;
    bit          nxt_we;
    #3;
    exp_ready = (phase == 1) && (cnt < DEPTH) && !finish;
    check("in_ready", in_ready, exp_ready);
    check("busy", busy, (phase == 1) || (phase == 2));
    check("full", full, cnt == DEPTH);
    check("illegal", illegal, ill);
    check("word_cnt", word_cnt, cnt);
    xfer   = in_valid && exp_ready;
    nxt_we = 0;
    if (xfer) begin
      enc = ref_enc(int'(op_sel), rs, rt, rd, shamt, funct, imm16);
      if (enc[32]) begin
        csum = csum ^ enc[31:0];
        sb.push_back('{BASE + 32'(4 * cnt), enc[31:0], cnt + 1, csum});
        cnt++;
        nxt_we = 1;
      end else begin
        ill = 1;
      end
    end
    case (phase)
      0, 3: if (start) begin phase = 1; cnt = 0; ill = 0; csum = 0; end
      1:    if (finish) phase = 2;
      2:    if (!we_out) phase = 3;
      default: ;
    endcase
    we_out = nxt_we;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 8 && busy; k++) cycle();
    check("done_reached", busy, 0);
  endtask

  always @(negedge clk) begin
    if (!reset && imem_we) begin
      nwrites++;
      if (sb.size() == 0) begin
        check("unexpected_write", imem_we, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", imem_addr, e.addr);
        check("wr_data", imem_wdata, e.data);
        check("wr_cnt", word_cnt, e.cnt);
`ifdef ENC_CHECKSUM_EN
        check("wr_checksum", checksum, e.csum);
`endif
      end
    end
  end

  initial begin
    int w0;
    reset = 1;
    idle_inputs();
    set_instr(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_cnt", word_cnt, 0);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_illegal", illegal, 0);
    check("rst_addr", imem_addr, BASE);
    check("rst_wdata", imem_wdata, 0);
`ifdef ENC_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif
    reset = 0;
    cycle();

    // Single LW, then back-to-back BALRN / JMADD.
    start = 1; cycle(); start = 0;
    set_instr(1, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010); in_valid = 1; cycle();
    check("t1_we", imem_we, 1);
    check("t1_wdata", imem_wdata, 32'h8C43_0010);
    check("t1_addr", imem_addr, BASE);
    check("t1_cnt", word_cnt, 1);
    set_instr(7, 5'd1, 5'd0, 5'd5, 5'd0, 6'd0, 16'h0); cycle();
    check("t2_balrn", imem_wdata, 32'h0020_2817);
    check("t2_addr0", imem_addr, BASE + 32'd4);
    set_instr(8, 5'd4, 5'd0, 5'd6, 5'd0, 6'd0, 16'h0); cycle();
    check("t2_jmadd", imem_wdata, 32'h0080_3021);
    check("t2_addr1", imem_addr, BASE + 32'd8);
    in_valid = 0; finish = 1; cycle(); finish = 0;
    wait_done();

    // Illegal op_sel between two legal transfers; checksum of the two words.
    w0 = nwrites;
    start = 1; cycle(); start = 0;
    set_instr(1, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010); in_valid = 1; cycle();
    set_instr(12, 5'd7, 5'd7, 5'd7, 5'd7, 6'd7, 16'h7777); cycle();
    set_instr(4, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'hFFFF); cycle();
    in_valid = 0; cycle();
    check("t3_illegal", illegal, 1);
    check("t3_nwrites", nwrites - w0, 2);
    check("t3_last_addr", imem_addr, BASE + 32'd4);
`ifdef ENC_CHECKSUM_EN
    check("t6_checksum", checksum, 32'hB862_FFEF);
`endif
    finish = 1; cycle(); finish = 0;
    wait_done();

    // Fill to DEPTH with in_valid held; the fifth instruction must be refused.
    start = 1; cycle(); start = 0;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      set_instr(i % 7, 5'(i), 5'(i + 1), 5'(i + 2), 5'(i), 6'(i), 16'(i * 16'h1111));
      cycle();
    end
    check("t4_full", full, 1);
    check("t4_ready", in_ready, 0);
    check("t4_cnt", word_cnt, DEPTH);
    check("t4_addr_max", imem_addr, BASE + 32'(4 * (DEPTH - 1)));
    in_valid = 0; finish = 1; cycle(); finish = 0;
    wait_done();

    // Reset arriving while a transfer is pending: no write, outputs back to reset values.
    start = 1; cycle(); start = 0;
    set_instr(4, 5'd3, 5'd9, 5'd0, 5'd0, 6'd0, 16'h1234); in_valid = 1;
    #3 reset = 1;
    @(posedge clk); #1;
    check("t5_we", imem_we, 0);
    check("t5_addr", imem_addr, BASE);
    check("t5_wdata", imem_wdata, 0);
    check("t5_busy", busy, 0);
    check("t5_cnt", word_cnt, 0);
    reset = 0; idle_inputs(); model_reset();
    cycle();
    start = 1; cycle(); start = 0;
    set_instr(2, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0004); in_valid = 1; cycle(); in_valid = 0;
    check("t5_restart_addr", imem_addr, BASE);
    check("t5_restart_we", imem_we, 1);
    finish = 1; cycle(); finish = 0;
    wait_done();

    // Randomized sessions, including stray start pulses and finish alongside in_valid.
    for (int s = 0; s < 40; s++) begin
      int n;
      start = 1; cycle(); start = 0;
      n = int'($urandom_range(2, 10));
      for (int i = 0; i < n; i++) begin
        in_valid = ($urandom % 4) != 0;
        set_instr(($urandom % 8 == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8)),
                  5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
                  16'($urandom));
        start  = ($urandom % 10) == 0;
        finish = (i == n - 1);
        cycle();
      end
      idle_inputs();
      wait_done();
    end

    cycle();
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
